// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - skews A columns and B rows onto the left and top edges of an NxN systolic array
// Each lane i delays an accepted beat by 1+i cycles; bubbles travel as zeroed slots.
module systolic_feeder #(
    parameter int N  = 8,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_a,
    input  logic [N*DW-1:0] in_b,
    input  logic            in_last,
    output logic [N*DW-1:0] aleft,
    output logic [N-1:0]    enleft,
    output logic [N-1:0]    cmleft,
    output logic [N*DW-1:0] bup,
    output logic [N-1:0]    enup,
    output logic [N-1:0]    cmup,
    output logic            busy,
    output logic            done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q;
    logic            accept;

    // ready_q holds in_ready low for the first cycle after reset is released
    assign in_ready = ready_q && (state_q != DRAIN);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != IDLE);
    assign done     = cmleft[N-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        state_d = DRAIN;
                        cnt_d   = CW'(N - 1);
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DW-1:0] a_sr_q [gi+1];
        logic [DW-1:0] b_sr_q [gi+1];
        logic [gi:0]   en_sr_q;
        logic [gi:0]   cm_sr_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int s = 0; s <= gi; s++) begin
                    a_sr_q[s] <= '0;
                    b_sr_q[s] <= '0;
                end
                en_sr_q <= '0;
                cm_sr_q <= '0;
            end else begin
                a_sr_q[0]  <= accept ? in_a[gi*DW +: DW] : '0;
                b_sr_q[0]  <= accept ? in_b[gi*DW +: DW] : '0;
                en_sr_q[0] <= accept;
                cm_sr_q[0] <= accept && in_last;
                for (int s = 1; s <= gi; s++) begin
                    a_sr_q[s]  <= a_sr_q[s-1];
                    b_sr_q[s]  <= b_sr_q[s-1];
                    en_sr_q[s] <= en_sr_q[s-1];
                    cm_sr_q[s] <= cm_sr_q[s-1];
                end
            end
        end

        assign aleft[gi*DW +: DW] = a_sr_q[gi];
        assign bup[gi*DW +: DW]   = b_sr_q[gi];
        assign enleft[gi]         = en_sr_q[gi];
        assign enup[gi]           = en_sr_q[gi];
        assign cmleft[gi]         = cm_sr_q[gi];
        assign cmup[gi]           = cm_sr_q[gi];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - scoreboard bench for systolic_feeder
// Per-lane queues hold the slot each lane must show on a given cycle; all other cycles must be zero.
module tb_systolic_feeder;

    localparam int N  = 8;
    localparam int DW = 32;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          cm;
    } slot_t;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_a;
    logic [N*DW-1:0] in_b;
    logic            in_last;
    logic [N*DW-1:0] aleft;
    logic [N-1:0]    enleft;
    logic [N-1:0]    cmleft;
    logic [N*DW-1:0] bup;
    logic [N-1:0]    enup;
    logic [N-1:0]    cmup;
    logic            busy;
    logic            done;

    systolic_feeder #(.N(N), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .aleft    (aleft),
        .enleft   (enleft),
        .cmleft   (cmleft),
        .bup      (bup),
        .enup     (enup),
        .cmup     (cmup),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    bit    mon_on = 1'b0;
    slot_t exp_q [N][$];

    // Behavioural model of the handshake: 0 idle, 1 streaming, 2 draining
    int    m_state = 0;
    int    m_left  = 0;
    bit    m_rdy_ok = 1'b0;
    logic  exp_rdy = 1'b0;
    logic  exp_busy = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic             done_exp;
        slot_t            s;
        logic [2*DW+3:0]  e;
        logic [2*DW+3:0]  o;
        if (mon_on) begin
            done_exp = 1'b0;
            for (int i = 0; i < N; i++) begin
                e = '0;
                if (exp_q[i].size() > 0 && int'(exp_q[i][0].cyc) == cyc) begin
                    s = exp_q[i].pop_front();
                    e = {s.a, s.b, 1'b1, 1'b1, s.cm, s.cm};
                    if (i == N - 1) done_exp = s.cm;
                end
                o = {aleft[i*DW +: DW], bup[i*DW +: DW], enleft[i], enup[i], cmleft[i], cmup[i]};
                vectors++;
                assert (o === e) else begin
                    miscompares++;
                    $error("FAIL lane%0d cyc%0d observed %h expected %h", i, cyc, o, e);
                end
            end
            vectors++;
            assert (done === done_exp) else begin
                miscompares++;
                $error("FAIL done cyc%0d observed %b expected %b", cyc, done, done_exp);
            end
            vectors++;
            assert ({in_ready, busy} === {exp_rdy, exp_busy}) else begin
                miscompares++;
                $error("FAIL ready_busy cyc%0d observed %b%b expected %b%b",
                       cyc, in_ready, busy, exp_rdy, exp_busy);
            end
        end
    end

    task automatic upd_exp();
        exp_rdy  = m_rdy_ok && (m_state != 2);
        exp_busy = (m_state != 0);
    endtask

    task automatic drive(input bit v, input bit last, input int base);
        bit acc;
        in_valid = v;
        in_last  = last;
        for (int i = 0; i < N; i++) begin
            in_a[i*DW +: DW] = DW'(base + i);
            in_b[i*DW +: DW] = DW'(32'hB000 + base + i);
        end
        acc = v && exp_rdy;
        if (acc) begin
            for (int i = 0; i < N; i++)
                exp_q[i].push_back('{cyc: 32'(cyc + 1 + i), a: DW'(base + i),
                                     b: DW'(32'hB000 + base + i), cm: last});
        end
        @(posedge clk);
        if (acc) begin
            m_state = last ? 2 : 1;
            if (last) m_left = N;
        end else if (m_state == 2) begin
            m_left--;
            if (m_left == 0) m_state = 0;
        end
        upd_exp();
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        for (int i = 0; i < N; i++) exp_q[i].delete();
        m_state  = 0;
        m_left   = 0;
        m_rdy_ok = 1'b0;
        upd_exp();
        mon_on   = 1'b1;
        #1;
        for (int c = 1; c < n; c++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        m_rdy_ok = 1'b1;
        upd_exp();
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = '0;
        in_b     = '0;

        do_reset(3);

        // K=3 back-to-back tile, then a beat offered mid-drain that must be ignored
        for (int k = 0; k < 3; k++) drive(1'b1, k == 2, 16 * k);
        for (int c = 0; c < 12; c++) drive(c == 3, 1'b0, 'h70);

        // single-beat tile
        drive(1'b1, 1'b1, 'h200);
        for (int c = 0; c < 10; c++) drive(1'b0, 1'b0, 'h300);

        // K=4 with a bubble after beat 1
        drive(1'b1, 1'b0, 'h400);
        drive(1'b1, 1'b0, 'h410);
        drive(1'b0, 1'b0, 'h420);
        drive(1'b1, 1'b0, 'h430);
        drive(1'b1, 1'b1, 'h440);
        for (int c = 0; c < 10; c++) drive(1'b0, 1'b0, 'h4F0);

        // second tile offered on the cycle right after done
        drive(1'b1, 1'b0, 'h500);
        drive(1'b1, 1'b1, 'h510);
        for (int c = 0; c < N; c++) drive(1'b0, 1'b0, 'h5F0);
        drive(1'b1, 1'b0, 'h600);
        drive(1'b1, 1'b1, 'h610);
        for (int c = 0; c < 10; c++) drive(1'b0, 1'b0, 'h6F0);

        // reset two beats into a K=5 tile discards everything in flight
        drive(1'b1, 1'b0, 'h700);
        drive(1'b1, 1'b0, 'h710);
        do_reset(1);
        for (int c = 0; c < 12; c++) drive(1'b0, 1'b0, 'h7F0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter N, default 8: array dimension, which is the number of row lanes (A) and column lanes (B).
REQ-002 Parameter DW, default 32: operand width in bits.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: synchronous active-low reset, sampled on the clk rising edge.
REQ-005 Port in_valid, input, 1: the upstream beat is valid.
REQ-006 Port in_ready, output, 1: the feeder can accept a beat.
REQ-007 Port in_a, input, N x DW: column k of A, where lane i carries A[i][k].
REQ-008 Port in_b, input, N x DW: row k of B, where lane j carries B[k][j].
REQ-009 Port in_last, input, 1: the beat is the final k of the tile.
REQ-010 Port aleft, output, N x DW: skewed A to the array's left edge.
REQ-011 Port enleft, output, N: per-row operand-valid to the left edge.
REQ-012 Port cmleft, output, N: per-row commit (final operand) to the left edge.
REQ-013 Port bup, output, N x DW: skewed B to the array's top edge.
REQ-014 Port enup, output, N: per-column operand-valid to the top edge.
REQ-015 Port cmup, output, N: per-column commit to the top edge.
REQ-016 Port busy, output, 1: a tile is in flight (state is not IDLE).
REQ-017 Port done, output, 1: one-cycle pulse marking the emission of the final skewed commit.

Function
REQ-018 A beat is accepted on a cycle where in_valid=1, in_ready=1 and rst=1.
REQ-019 FSM states and transitions:
- IDLE -> STREAM on an accepted beat with in_last=0.
- IDLE -> DRAIN on an accepted beat with in_last=1.
- STREAM -> DRAIN on an accepted beat with in_last=1.
- DRAIN -> IDLE when the drain counter expires.
REQ-020 in_ready shall be 1 in IDLE and STREAM and 0 in DRAIN.
REQ-021 Lane i (A side) and lane j (B side) shall delay the accepted beat by 1+i and 1+j cycles respectively, using per-lane shift registers.
REQ-022 For a beat accepted at cycle t, aleft[i]=in_a[i], enleft[i]=1 and cmleft[i]=in_last at cycle t+1+i; the B side behaves the same with bup/enup/cmup and lane index j.
REQ-023 Cycles with no accepted beat (bubbles) shall inject a slot with en=0, cm=0 and data=0, preserving the skew alignment of all later beats.
REQ-024 Whenever en=0 on a lane, the data on that lane shall be 0 and cm shall be 0.
REQ-025 cm on a lane shall never be 1 unless en on the same lane is 1.
REQ-026 The drain counter is a ceil(log2(N))-bit counter:
- It loads N-1 when in_last is accepted.
- It decrements once per cycle in DRAIN.
- The FSM leaves DRAIN after the cycle on which the counter equals 0, so DRAIN lasts exactly N cycles.
REQ-027 done shall pulse for exactly one cycle, coincident with cmleft[N-1]=1 (equivalently cmup[N-1]=1), i.e. at t_last+N.
REQ-028 busy shall be 1 from the cycle after the first accepted beat through the cycle done is asserted, inclusive.
REQ-029 A one-beat tile (first beat has in_last=1) shall be legal and take the IDLE -> DRAIN path.
REQ-030 A new tile may be accepted in IDLE on the cycle immediately after done; no overlap between tiles is permitted.
REQ-031 The block shall perform no arithmetic on data; widths pass through unchanged.
REQ-032 Beats offered while in_ready=0 shall not be consumed and shall not alter any state.

Reset
REQ-033 While rst=0 at a clock edge, the FSM shall go to IDLE, all shift stages shall clear to data=0/en=0/cm=0, and the drain counter shall clear to 0.
REQ-034 During reset and on the first cycle after it: aleft=0, bup=0, enleft=0, enup=0, cmleft=0, cmup=0, busy=0, done=0, in_ready=0.
REQ-035 in_ready shall be 1 from the second cycle after reset deassertion.
REQ-036 Reset mid-tile shall discard all in-flight slots with no partial en or cm emitted afterwards.

Verification
REQ-037 N=8, K=3 back-to-back beats with a[i]=16*k+i, last on k=2 -> aleft[i]=16*k+i at cycle t0+1+k+i; cmleft[7]=1 only at t0+10; done=1 at t0+10.
REQ-038 K=1 tile with in_last on the first beat -> enleft[i]=cmleft[i]=1 at t0+1+i; in_ready=0 for 8 cycles, then 1.
REQ-039 K=4 with a bubble after beat 1 -> lane 0 en pattern 1,1,0,1,1; all lanes carry the same pattern shifted by i; data=0 in the bubble slot.
REQ-040 Beat offered during DRAIN -> not accepted; outputs match a run without the offer.
REQ-041 rst=0 asserted 2 cycles into a K=5 tile -> all en/cm/data=0 from the next cycle; done never asserts; in_ready returns to 1 on the second cycle after rst returns to 1.
REQ-042 Two tiles, the second offered on the cycle after done -> accepted immediately; skew of the second tile is identical to that of the first.
